// File: rtl/cam_entry_mgr_pkg.sv
// Shared encodings for the CAM entry manager: request ops, response status codes and FSM states.
package cam_entry_mgr_pkg;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_REMOVE = 1'b1;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_DUP       = 2'b01;
  localparam logic [1:0] ST_FULL      = 2'b10;
  localparam logic [1:0] ST_NOT_FOUND = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLookup = 3'd1,
    StIssue  = 3'd2,
    StWait   = 3'd3,
    StResp   = 3'd4
  } state_e;

endpackage

// File: rtl/cam_entry_mgr_priority_encoder.sv
// Priority encoder: returns the index of the highest-priority set bit and whether any bit is set.
module cam_entry_mgr_priority_encoder #(
  parameter int unsigned WIDTH        = 4,
  parameter string       LSB_PRIORITY = "HIGH",
  localparam int unsigned IdxW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] unencoded_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  encoded_o
);

  always_comb begin
    valid_o   = |unencoded_i;
    encoded_o = '0;
    if (LSB_PRIORITY == "HIGH") begin
      // Scan downwards so the lowest set index is written last and wins.
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (unencoded_i[i]) encoded_o = IdxW'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (unencoded_i[i]) encoded_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/cam_entry_mgr.sv
// Request-side CAM controller: key-level insert/remove, slot allocation and occupancy tracking.
// Optional flush support is enabled by defining CAM_ENTRY_MGR_FLUSH_EN.
module cam_entry_mgr
  import cam_entry_mgr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CAM_ENTRY_MGR_FLUSH_EN
  input  logic                  flush,
  output logic                  cam_rst_clr,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_enable,
  output logic                  cam_write_delete,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned RamDepth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW     = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            status_q, status_d;
  logic [RamDepth-1:0]   bitmap_q, bitmap_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  wait_first_q, wait_first_d;

  logic                  free_vld;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  flush_block;
  logic                  req_fire;
  logic                  issue_go;

  cam_entry_mgr_priority_encoder #(
    .WIDTH        (RamDepth),
    .LSB_PRIORITY ("HIGH")
  ) u_free_slot (
    .unencoded_i (~bitmap_q),
    .valid_o     (free_vld),
    .encoded_o   (free_idx)
  );

`ifdef CAM_ENTRY_MGR_FLUSH_EN
  logic flush_hold_q, flush_hold_d;
  logic flush_first_q, flush_first_d;
  logic rst_clr_q, rst_clr_d;
  logic flush_take;

  assign flush_take  = (state_q == StIdle) && flush && !flush_hold_q;
  assign flush_block = flush || flush_hold_q;
  assign cam_rst_clr = rst_clr_q;

  // The CAM raises busy a cycle after rst_clr, so the first hold cycle ignores busy.
  always_comb begin
    flush_hold_d  = flush_hold_q;
    flush_first_d = 1'b0;
    rst_clr_d     = 1'b0;
    if (flush_take) begin
      flush_hold_d  = 1'b1;
      flush_first_d = 1'b1;
      rst_clr_d     = 1'b1;
    end else if (flush_hold_q && !flush_first_q && !cam_write_busy) begin
      flush_hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_hold_q  <= 1'b0;
      flush_first_q <= 1'b0;
      rst_clr_q     <= 1'b0;
    end else begin
      flush_hold_q  <= flush_hold_d;
      flush_first_q <= flush_first_d;
      rst_clr_q     <= rst_clr_d;
    end
  end
`else
  assign flush_block = 1'b0;
`endif

  assign req_ready        = !rst && (state_q == StIdle) && !cam_write_busy && !flush_block;
  assign req_fire         = req_valid && req_ready;
  assign issue_go         = !rst && (state_q == StIssue) && !cam_write_busy;
  assign cam_write_enable = issue_go && (op_q == OP_INSERT);
  assign cam_write_delete = issue_go && (op_q == OP_REMOVE);
  assign cam_write_addr   = addr_q;
  assign cam_write_data   = key_q;
  assign cam_compare_data = key_q;
  assign rsp_valid        = (state_q == StResp);
  assign rsp_status       = status_q;
  assign rsp_addr         = addr_q;
  assign entry_count      = count_q;
  assign full             = (count_q == CntW'(RamDepth));
  assign empty            = (count_q == '0);

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    op_d         = op_q;
    addr_d       = addr_q;
    status_d     = status_q;
    bitmap_d     = bitmap_q;
    count_d      = count_q;
    wait_first_d = 1'b0;
    unique case (state_q)
      StIdle: begin
`ifdef CAM_ENTRY_MGR_FLUSH_EN
        if (flush_take) begin
          bitmap_d = '0;
          count_d  = '0;
        end
`endif
        if (req_fire) begin
          key_d   = req_key;
          op_d    = req_op;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (op_q == OP_INSERT) begin
          if (cam_match) begin
            status_d = ST_DUP;
            addr_d   = cam_match_addr;
            state_d  = StResp;
          end else if (!free_vld) begin
            status_d = ST_FULL;
            addr_d   = '0;
            state_d  = StResp;
          end else begin
            addr_d  = free_idx;
            state_d = StIssue;
          end
        end else if (cam_match) begin
          addr_d  = cam_match_addr;
          state_d = StIssue;
        end else begin
          status_d = ST_NOT_FOUND;
          addr_d   = '0;
          state_d  = StResp;
        end
      end
      StIssue: begin
        if (!cam_write_busy) begin
          bitmap_d[addr_q] = (op_q == OP_INSERT);
          count_d          = (op_q == OP_INSERT) ? count_q + CntW'(1) : count_q - CntW'(1);
          wait_first_d     = 1'b1;
          state_d          = StWait;
        end
      end
      StWait: begin
        // Busy lags the strobe by a cycle, so the first wait cycle cannot trust it.
        if (!wait_first_q && !cam_write_busy) begin
          status_d = ST_OK;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      key_q        <= '0;
      op_q         <= OP_INSERT;
      addr_q       <= '0;
      status_q     <= ST_OK;
      bitmap_q     <= '0;
      count_q      <= '0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      status_q     <= status_d;
      bitmap_q     <= bitmap_d;
      count_q      <= count_d;
      wait_first_q <= wait_first_d;
    end
  end

endmodule

// File: doc/cam_entry_mgr.md
# cam_entry_mgr

Request-side controller for the block-RAM CAM. Accepts key-level insert/remove requests over a valid/ready handshake and drives the CAM write port. Before committing a write, looks the key up through the CAM compare port, allocates the lowest free slot on insert, and tracks occupancy. Returns a per-request status and address on a valid/ready response channel, so upstream logic never manages CAM addresses directly.

## Interface
Parameters:
- DATA_WIDTH, 16, key width; must equal the CAM's DATA_WIDTH.
- ADDR_WIDTH, 5, log2 entry count; RAM_DEPTH = 2**ADDR_WIDTH.

Ports:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_op  in  1  0 = insert, 1 = remove.
- req_key  in  DATA_WIDTH  key.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_status  out  2  00 OK, 01 DUP, 10 FULL, 11 NOT_FOUND.
- rsp_addr  out  ADDR_WIDTH  slot affected or matched; 0 for FULL/NOT_FOUND.
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr.
- cam_write_data  out  DATA_WIDTH  to CAM write_data.
- cam_write_enable  out  1  to CAM write_enable.
- cam_write_delete  out  1  to CAM write_delete.
- cam_write_busy  in  1  from CAM write_busy.
- cam_compare_data  out  DATA_WIDTH  to CAM compare_data.
- cam_match  in  1  from CAM match.
- cam_match_addr  in  ADDR_WIDTH  from CAM match_addr.
- entry_count  out  ADDR_WIDTH+1  valid entries.
- full  out  1  entry_count == RAM_DEPTH.
- empty  out  1  entry_count == 0.

## Operation
- State: valid bitmap (RAM_DEPTH bits), key_reg, op_reg, hit_reg, addr_reg, status_reg.
- cam_compare_data = key_reg at all times. cam_write_data = key_reg. cam_write_addr = addr_reg.
- FSM states and transitions:
  - IDLE: req_ready = !cam_write_busy. On handshake, latch key/op and go to LOOKUP.
  - LOOKUP: one cycle. Sample cam_match and cam_match_addr at the closing edge.
    - Insert with hit: go to RESP, status DUP, addr = match_addr.
    - Insert, no hit, full: go to RESP, status FULL, addr 0.
    - Insert, no hit, not full: go to ISSUE, addr = lowest clear bitmap index.
    - Remove with hit: go to ISSUE, addr = match_addr.
    - Remove, no hit: go to RESP, status NOT_FOUND, addr 0.
  - ISSUE: hold while cam_write_busy. When busy is low, assert exactly one of cam_write_enable (insert) or cam_write_delete (remove) for one cycle. On the same edge, set or clear the bitmap bit and increment or decrement entry_count. Then go to WAIT.
  - WAIT: ignore busy on the first cycle, since the CAM raises busy one cycle after the strobe. Then stay until busy is low. Go to RESP with status OK.
  - RESP: rsp_valid high, outputs stable until rsp_ready. Then go to IDLE.
- Exactly one request is outstanding at a time; there is no pipelining.
- cam_write_enable and cam_write_delete are never high together.
- Reset values:
  - Outputs: req_ready 0 (the CAM holds busy through its init sweep), rsp_valid 0, rsp_status 00, rsp_addr 0, write strobes 0, entry_count 0, empty 1, full 0.
  - Internal: bitmap all zero, key_reg 0.
- Reset mid-operation aborts the request; the response is lost and no strobe is emitted after the reset edge.

## Timing
- Insert/remove with a write: accept edge, then LOOKUP 1 cycle, ISSUE ≥1 cycle, WAIT ≥2 cycles, then RESP. Minimum 5 cycles from accept to rsp_valid.
- DUP, FULL or NOT_FOUND: rsp_valid 2 cycles after accept.
- Back-to-back requests: next req_ready comes the cycle after the rsp handshake, gated by busy.
- Match results are sampled one full cycle after key_reg updates. This covers the CAM's negedge compare read.

## Configuration
- CAM_ENTRY_MGR_FLUSH_EN defined:
  - Adds input flush and output cam_rst_clr (to CAM rst_clr).
  - flush is honoured only in IDLE. It pulses cam_rst_clr for 1 cycle, clears the bitmap and entry_count, and forces req_ready 0 until cam_write_busy falls.
  - flush takes priority over a simultaneous req_valid; the request is not accepted that cycle.
- Macro undefined: no flush port, no cam_rst_clr port, no flush logic.

## Structure
- Package cam_entry_mgr_pkg:
  - op encodings (OP_INSERT, OP_REMOVE);
  - status encodings (ST_OK, ST_DUP, ST_FULL, ST_NOT_FOUND);
  - FSM state localparams.
- One sub-module: the existing priority_encoder (WIDTH = RAM_DEPTH, LSB_PRIORITY "HIGH") on ~bitmap, which yields the free slot and a not-full valid.

## Test plan
- After reset, hold req_valid: req_ready stays 0 until CAM busy drops. Then insert 0x1234 -> OK, addr 0, entry_count 1.
- Insert 0x1234 again -> DUP, addr 0, no write strobe, entry_count unchanged.
- Insert 0xAAAA, 0xBBBB, remove 0xAAAA, insert 0xCCCC -> 0xCCCC gets addr 1 (lowest free), entry_count 3.
- Remove 0x5555 (absent) -> NOT_FOUND, addr 0, no strobe. Insert into 32 distinct keys then a 33rd -> FULL, full=1.
- Hold rsp_ready low 10 cycles -> rsp fields stable, req_ready 0. Assert rst during WAIT -> no response, entry_count 0.
- With CAM_ENTRY_MGR_FLUSH_EN: 3 entries, flush -> cam_rst_clr one-cycle pulse, entry_count 0, then insert 0x1234 -> OK, addr 0.
